// File: rtl/mips_decode_pkg.sv
// ============================================================
// mips_decode_pkg: shared types and constants for the decode-stage RF port.
// Rev 1.0
// ============================================================
`default_nettype none

package mips_decode_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;

    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        HOLD    = 2'd2
    } state_e;

endpackage

`default_nettype wire

// File: rtl/rf_arbiter.sv
// ============================================================
// rf_arbiter: issue-slot read/write grant with write-starvation limit.
// Rev 1.0
// ============================================================
`default_nettype none

module rf_arbiter #(
    parameter int STARVE_MAX = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic issue_slot,
    input  logic in_valid,
    input  logic wb_valid,
    output logic rd_grant,
    output logic wr_grant
);

    localparam int SW = $clog2(STARVE_MAX + 2);

    logic [SW-1:0] starve_q;
    logic [SW-1:0] starve_d;
    logic          starved;

    always_comb begin
        starved  = (starve_q == SW'(STARVE_MAX));
        rd_grant = issue_slot & in_valid & (~wb_valid | starved);
        wr_grant = issue_slot & wb_valid & ~rd_grant;
        starve_d = starve_q;
        if (rd_grant) begin
            starve_d = '0;
        end else if (wr_grant && in_valid) begin
            starve_d = starve_q + SW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/regfile_port_ctrl.sv
// ============================================================
// regfile_port_ctrl: sequences operand reads and writebacks onto the RF port.
// Rev 1.0
// ============================================================
`default_nettype none

module regfile_port_ctrl
    import mips_decode_pkg::*;
#(
    parameter int STARVE_MAX = 4,
    parameter int RD_TIMEOUT = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_W-1:0]     in_instr,
    input  logic [REG_ADDR_W-1:0] in_rs,
    input  logic [REG_ADDR_W-1:0] in_rt,
    input  logic                  wb_valid,
    output logic                  wb_ready,
    input  logic [REG_ADDR_W-1:0] wb_reg,
    input  logic [DATA_W-1:0]     wb_data,
    output logic                  rf_rd_en,
    output logic [REG_ADDR_W-1:0] rf_rd_reg1,
    output logic [REG_ADDR_W-1:0] rf_rd_reg2,
    output logic                  rf_reg_write,
    output logic [REG_ADDR_W-1:0] rf_write_reg,
    output logic [DATA_W-1:0]     rf_write_data,
    input  logic [DATA_W-1:0]     rf_rd_data1,
    input  logic [DATA_W-1:0]     rf_rd_data2,
    input  logic                  rf_valid_out,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_W-1:0]     out_instr,
    output logic [DATA_W-1:0]     out_rs_data,
    output logic [DATA_W-1:0]     out_rt_data,
    output logic                  rd_retry
);

    localparam int TW = $clog2(RD_TIMEOUT + 2);

    state_e                state_q, state_d;
    logic [DATA_W-1:0]     instr_q, instr_d;
    logic [REG_ADDR_W-1:0] rs_q, rs_d, rt_q, rt_d;
    logic [DATA_W-1:0]     rs_data_q, rs_data_d, rt_data_q, rt_data_d;
    logic [TW-1:0]         tmo_q, tmo_d;

    logic issue_slot;
    logic rd_grant;
    logic wr_grant;
    logic retry;

    // Gated by rst_n so nothing is granted while reset is held.
    always_comb begin
        issue_slot = rst_n & ((state_q == IDLE) | ((state_q == HOLD) & out_ready));
    end

    rf_arbiter #(
        .STARVE_MAX (STARVE_MAX)
    ) u_rf_arbiter (
        .clk        (clk),
        .rst_n      (rst_n),
        .issue_slot (issue_slot),
        .in_valid   (in_valid),
        .wb_valid   (wb_valid),
        .rd_grant   (rd_grant),
        .wr_grant   (wr_grant)
    );

    always_comb begin
        wb_ready      = issue_slot ? wr_grant : (state_q != IDLE);
        rf_reg_write  = wb_valid & wb_ready & (wb_reg != REG_ZERO);
        // A due reissue waits out any same-cycle write so the two never collide.
        retry         = (state_q == RD_WAIT) & ~rf_valid_out &
                        (tmo_q == TW'(RD_TIMEOUT)) & ~rf_reg_write;
        rf_rd_en      = rd_grant | retry;
        rf_rd_reg1    = rd_grant ? in_rs : (retry ? rs_q : '0);
        rf_rd_reg2    = rd_grant ? in_rt : (retry ? rt_q : '0);
        rf_write_reg  = rf_reg_write ? wb_reg  : '0;
        rf_write_data = rf_reg_write ? wb_data : '0;
        in_ready      = rd_grant;
        rd_retry      = retry;
        out_valid     = (state_q == HOLD);
        out_instr     = instr_q;
        out_rs_data   = rs_data_q;
        out_rt_data   = rt_data_q;
    end

    always_comb begin
        state_d   = state_q;
        instr_d   = instr_q;
        rs_d      = rs_q;
        rt_d      = rt_q;
        rs_data_d = rs_data_q;
        rt_data_d = rt_data_q;
        tmo_d     = '0;
        case (state_q)
            RD_WAIT: begin
                if (rf_valid_out) begin
                    rs_data_d = (rs_q == REG_ZERO) ? '0 : rf_rd_data1;
                    rt_data_d = (rt_q == REG_ZERO) ? '0 : rf_rd_data2;
                    state_d   = HOLD;
                end else if (!retry) begin
                    tmo_d = (tmo_q == TW'(RD_TIMEOUT)) ? tmo_q : tmo_q + TW'(1);
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = state_q;
        endcase
        if (rd_grant) begin
            instr_d = in_instr;
            rs_d    = in_rs;
            rt_d    = in_rt;
            state_d = RD_WAIT;
        end
        // Writes landing after the read was issued are not in the RF response; forward them.
        if ((state_q != IDLE) && rf_reg_write) begin
            if (wb_reg == rs_q) rs_data_d = wb_data;
            if (wb_reg == rt_q) rt_data_d = wb_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            instr_q   <= '0;
            rs_q      <= '0;
            rt_q      <= '0;
            rs_data_q <= '0;
            rt_data_q <= '0;
            tmo_q     <= '0;
        end else begin
            state_q   <= state_d;
            instr_q   <= instr_d;
            rs_q      <= rs_d;
            rt_q      <= rt_d;
            rs_data_q <= rs_data_d;
            rt_data_q <= rt_data_d;
            tmo_q     <= tmo_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_regfile_port_ctrl.sv
// ============================================================
// tb_regfile_port_ctrl: directed bench with a one-cycle-latency RF model.
// Rev 1.0
// ============================================================
`default_nettype none

module tb_regfile_port_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready;
    logic [31:0] in_instr;
    logic [4:0]  in_rs, in_rt;
    logic        wb_valid, wb_ready;
    logic [4:0]  wb_reg;
    logic [31:0] wb_data;
    logic        rf_rd_en;
    logic [4:0]  rf_rd_reg1, rf_rd_reg2;
    logic        rf_reg_write;
    logic [4:0]  rf_write_reg;
    logic [31:0] rf_write_data;
    logic [31:0] rf_rd_data1, rf_rd_data2;
    logic        rf_valid_out;
    logic        out_valid, out_ready;
    logic [31:0] out_instr, out_rs_data, out_rt_data;
    logic        rd_retry;

    int checks = 0;
    int errors = 0;
    int conflicts = 0;

    // Register-file model: read in N answers in N+1, write in N visible from N+1.
    logic [31:0] rf_mem [32];
    logic        model_valid = 1'b0;
    logic        suppress    = 1'b0;
    logic        force_valid = 1'b0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!rst_n) begin
            rf_mem[0] <= 32'hFF;
            rf_mem[3] <= 32'hAA;
            rf_mem[4] <= 32'hBB;
            rf_mem[7] <= 32'h77;
        end else if (rf_reg_write) begin
            rf_mem[rf_write_reg] <= rf_write_data;
        end
        model_valid <= rf_rd_en & ~suppress;
        rf_rd_data1 <= rf_mem[rf_rd_reg1];
        rf_rd_data2 <= rf_mem[rf_rd_reg2];
        if (rf_rd_en && rf_reg_write) conflicts <= conflicts + 1;
    end

    assign rf_valid_out = model_valid | force_valid;

    regfile_port_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_instr      (in_instr),
        .in_rs         (in_rs),
        .in_rt         (in_rt),
        .wb_valid      (wb_valid),
        .wb_ready      (wb_ready),
        .wb_reg        (wb_reg),
        .wb_data       (wb_data),
        .rf_rd_en      (rf_rd_en),
        .rf_rd_reg1    (rf_rd_reg1),
        .rf_rd_reg2    (rf_rd_reg2),
        .rf_reg_write  (rf_reg_write),
        .rf_write_reg  (rf_write_reg),
        .rf_write_data (rf_write_data),
        .rf_rd_data1   (rf_rd_data1),
        .rf_rd_data2   (rf_rd_data2),
        .rf_valid_out  (rf_valid_out),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_instr     (out_instr),
        .out_rs_data   (out_rs_data),
        .out_rt_data   (out_rt_data),
        .rd_retry      (rd_retry)
    );

    // Stimulus-only helper: acknowledge the held operands and return to IDLE.
    task automatic release_hold();
        @(negedge clk); out_ready = 1'b1;
        @(negedge clk); out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b1; wb_valid = 1'b1; wb_reg = 5'd6; wb_data = 32'h55;
        in_instr = 32'h1; in_rs = 5'd3; in_rt = 5'd4; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if ({in_ready, wb_ready, rf_rd_en, rf_reg_write, out_valid, rd_retry} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b want 000000",
                     {in_ready, wb_ready, rf_rd_en, rf_reg_write, out_valid, rd_retry});
        end
        checks++;
        if ({out_instr, out_rs_data, out_rt_data, rf_rd_reg1, rf_rd_reg2, rf_write_reg, rf_write_data} !== '0) begin
            errors++;
            $display("FAIL reset_data: instr=%h rs=%h rt=%h a1=%0d a2=%0d wr=%0d wd=%h want all 0",
                     out_instr, out_rs_data, out_rt_data, rf_rd_reg1, rf_rd_reg2, rf_write_reg, rf_write_data);
        end
        in_valid = 1'b0; wb_valid = 1'b0;
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_simple_read();
        @(negedge clk); in_valid = 1'b1; in_rs = 5'd3; in_rt = 5'd4; in_instr = 32'h1234_5678; #1;
        checks++;
        if ({in_ready, rf_rd_en, rf_rd_reg1, rf_rd_reg2} !== {1'b1, 1'b1, 5'd3, 5'd4}) begin
            errors++;
            $display("FAIL simple_issue: got rdy=%b en=%b a1=%0d a2=%0d want 1 1 3 4",
                     in_ready, rf_rd_en, rf_rd_reg1, rf_rd_reg2);
        end
        @(negedge clk); in_valid = 1'b0; #1;
        checks++;
        if ({rf_rd_en, out_valid} !== 2'b00) begin
            errors++;
            $display("FAIL simple_wait: got en=%b ov=%b want 0 0", rf_rd_en, out_valid);
        end
        @(negedge clk); #1;
        checks++;
        if ({out_valid, out_rs_data, out_rt_data, out_instr} !== {1'b1, 32'hAA, 32'hBB, 32'h1234_5678}) begin
            errors++;
            $display("FAIL simple_data: got ov=%b rs=%h rt=%h instr=%h want 1 aa bb 12345678",
                     out_valid, out_rs_data, out_rt_data, out_instr);
        end
        release_hold(); #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL simple_release: got ov=%b want 0", out_valid);
        end
    endtask

    task automatic test_write_then_read();
        @(negedge clk);
        wb_valid = 1'b1; wb_reg = 5'd5; wb_data = 32'h1234;
        in_valid = 1'b1; in_rs = 5'd5; in_rt = 5'd0; in_instr = 32'hA5A5_0005; #1;
        checks++;
        if ({wb_ready, rf_reg_write, rf_rd_en, in_ready, rf_write_reg} !== {4'b1100, 5'd5}) begin
            errors++;
            $display("FAIL wtr_write: got wr=%b we=%b en=%b ir=%b reg=%0d want 1 1 0 0 5",
                     wb_ready, rf_reg_write, rf_rd_en, in_ready, rf_write_reg);
        end
        @(negedge clk); wb_valid = 1'b0; #1;
        checks++;
        if ({rf_rd_en, rf_reg_write, rf_rd_reg1} !== {2'b10, 5'd5}) begin
            errors++;
            $display("FAIL wtr_read: got en=%b we=%b a1=%0d want 1 0 5", rf_rd_en, rf_reg_write, rf_rd_reg1);
        end
        @(negedge clk); in_valid = 1'b0;
        @(negedge clk); #1;
        checks++;
        if ({out_valid, out_rs_data, out_rt_data} !== {1'b1, 32'h1234, 32'h0}) begin
            errors++;
            $display("FAIL wtr_data: got ov=%b rs=%h rt=%h want 1 1234 0", out_valid, out_rs_data, out_rt_data);
        end
        release_hold();
    endtask

    task automatic test_patch_hold();
        @(negedge clk); in_valid = 1'b1; in_rs = 5'd7; in_rt = 5'd4; in_instr = 32'h7;
        @(negedge clk); in_valid = 1'b0;
        @(negedge clk); wb_valid = 1'b1; wb_reg = 5'd7; wb_data = 32'hDEAD; #1;
        checks++;
        if ({out_valid, out_rs_data, wb_ready, rf_reg_write} !== {1'b1, 32'h77, 2'b11}) begin
            errors++;
            $display("FAIL patch_before: got ov=%b rs=%h wr=%b we=%b want 1 77 1 1",
                     out_valid, out_rs_data, wb_ready, rf_reg_write);
        end
        @(negedge clk); wb_valid = 1'b0; #1;
        checks++;
        if ({out_valid, out_rs_data, out_rt_data} !== {1'b1, 32'hDEAD, 32'hBB}) begin
            errors++;
            $display("FAIL patch_after: got ov=%b rs=%h rt=%h want 1 dead bb", out_valid, out_rs_data, out_rt_data);
        end
        release_hold();
    endtask

    task automatic test_zero_reg();
        @(negedge clk); in_valid = 1'b1; in_rs = 5'd0; in_rt = 5'd3; in_instr = 32'h0;
        @(negedge clk); in_valid = 1'b0;
        @(negedge clk); #1;
        checks++;
        if ({out_valid, out_rs_data, out_rt_data} !== {1'b1, 32'h0, 32'hAA}) begin
            errors++;
            $display("FAIL zero_read: got ov=%b rs=%h rt=%h want 1 0 aa", out_valid, out_rs_data, out_rt_data);
        end
        release_hold();
        @(negedge clk); wb_valid = 1'b1; wb_reg = 5'd0; wb_data = 32'h1111; #1;
        checks++;
        if ({wb_ready, rf_reg_write} !== 2'b10) begin
            errors++;
            $display("FAIL zero_write: got wr=%b we=%b want 1 0", wb_ready, rf_reg_write);
        end
        @(negedge clk); wb_valid = 1'b0;
    endtask

    task automatic test_starvation();
        int writes = 0;
        int grant_at = -1;
        in_rs = 5'd9; in_rt = 5'd9; in_instr = 32'h9;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            wb_valid = 1'b1; wb_reg = 5'd9; wb_data = 32'h100 + i;
            in_valid = (grant_at < 0); #1;
            if (grant_at < 0) begin
                if (in_ready) begin
                    grant_at = i;
                    checks++;
                    if (wb_ready !== 1'b0) begin
                        errors++;
                        $display("FAIL starve_excl: got wr=%b want 0 on read grant", wb_ready);
                    end
                end else if (wb_ready) begin
                    writes++;
                end
            end
        end
        @(negedge clk); wb_valid = 1'b0; in_valid = 1'b0; #1;
        checks++;
        if (writes !== 4 || grant_at !== 4) begin
            errors++;
            $display("FAIL starve_count: got writes=%0d grant_cycle=%0d want 4 4", writes, grant_at);
        end
        checks++;
        if ({out_valid, out_rs_data, out_rt_data} !== {1'b1, 32'h109, 32'h109}) begin
            errors++;
            $display("FAIL starve_patch: got ov=%b rs=%h rt=%h want 1 109 109", out_valid, out_rs_data, out_rt_data);
        end
        release_hold();
    endtask

    task automatic test_timeout();
        int early = 0;
        suppress = 1'b1;
        @(negedge clk); in_valid = 1'b1; in_rs = 5'd3; in_rt = 5'd4; in_instr = 32'h3; #1;
        checks++;
        if (rf_rd_en !== 1'b1) begin
            errors++;
            $display("FAIL tmo_issue: got en=%b want 1", rf_rd_en);
        end
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk); in_valid = 1'b0; #1;
            if (rf_rd_en || rd_retry) early++;
        end
        checks++;
        if (early !== 0) begin
            errors++;
            $display("FAIL tmo_early: got %0d early reissue cycles want 0", early);
        end
        @(negedge clk); suppress = 1'b0; #1;
        checks++;
        if ({rd_retry, rf_rd_en, rf_rd_reg1, rf_rd_reg2} !== {2'b11, 5'd3, 5'd4}) begin
            errors++;
            $display("FAIL tmo_retry: got rt=%b en=%b a1=%0d a2=%0d want 1 1 3 4",
                     rd_retry, rf_rd_en, rf_rd_reg1, rf_rd_reg2);
        end
        @(negedge clk); #1;
        checks++;
        if ({rd_retry, out_valid} !== 2'b00) begin
            errors++;
            $display("FAIL tmo_pulse: got rt=%b ov=%b want 0 0", rd_retry, out_valid);
        end
        @(negedge clk); #1;
        checks++;
        if ({out_valid, out_rs_data, out_rt_data} !== {1'b1, 32'hAA, 32'hBB}) begin
            errors++;
            $display("FAIL tmo_data: got ov=%b rs=%h rt=%h want 1 aa bb", out_valid, out_rs_data, out_rt_data);
        end
        release_hold();
    endtask

    task automatic test_reset_mid_op();
        suppress = 1'b1;
        @(negedge clk); in_valid = 1'b1; in_rs = 5'd3; in_rt = 5'd4; in_instr = 32'hCAFE_0001;
        @(negedge clk); in_valid = 1'b0; wb_valid = 1'b1; wb_reg = 5'd6; wb_data = 32'h66; rst_n = 1'b0; #1;
        checks++;
        if ({in_ready, wb_ready, rf_rd_en, rf_reg_write, out_valid, rd_retry, out_instr, out_rs_data} !== '0) begin
            errors++;
            $display("FAIL rst_mid: got ctl=%b instr=%h rs=%h want all 0",
                     {in_ready, wb_ready, rf_rd_en, rf_reg_write, out_valid, rd_retry}, out_instr, out_rs_data);
        end
        @(negedge clk); rst_n = 1'b1; wb_valid = 1'b0; suppress = 1'b0; force_valid = 1'b1;
        @(negedge clk); force_valid = 1'b0; #1;
        checks++;
        if ({out_valid, rf_rd_en, wb_ready} !== 3'b000) begin
            errors++;
            $display("FAIL rst_late_valid: got ov=%b en=%b wr=%b want 0 0 0", out_valid, rf_rd_en, wb_ready);
        end
        @(negedge clk); in_valid = 1'b1; in_rs = 5'd4; in_rt = 5'd3; in_instr = 32'h43; #1;
        checks++;
        if ({in_ready, rf_rd_en} !== 2'b11) begin
            errors++;
            $display("FAIL rst_idle_issue: got ir=%b en=%b want 1 1", in_ready, rf_rd_en);
        end
        @(negedge clk); in_valid = 1'b0;
        @(negedge clk); #1;
        checks++;
        if ({out_valid, out_rs_data, out_rt_data, out_instr} !== {1'b1, 32'hBB, 32'hAA, 32'h43}) begin
            errors++;
            $display("FAIL rst_recover: got ov=%b rs=%h rt=%h instr=%h want 1 bb aa 43",
                     out_valid, out_rs_data, out_rt_data, out_instr);
        end
        release_hold();
    endtask

    task automatic test_no_conflict();
        @(negedge clk); #1;
        checks++;
        if (conflicts !== 0) begin
            errors++;
            $display("FAIL rd_wr_exclusive: got %0d cycles with rf_rd_en and rf_reg_write want 0", conflicts);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_simple_read();
        test_write_then_read();
        test_patch_hold();
        test_zero_reg();
        test_starvation();
        test_timeout();
        test_reset_mid_op();
        test_no_conflict();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
